// File: rtl/sram_word_controller_if.sv
// Pipeline-side bundle of the SRAM word controller: strobes, address, data, ready.
// Carries addr_err only when SRAM_RANGE_CHECK_EN is defined.
interface sram_word_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
`ifdef SRAM_RANGE_CHECK_EN
    logic        addr_err;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready, addr_err
    );
    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready, addr_err
    );
`else
    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );
    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );
`endif
endinterface

// File: rtl/sram_word_controller.sv
// 32-bit load/store over a 16-bit asynchronous SRAM as two half-word accesses.
// Optional macro SRAM_RANGE_CHECK_EN rejects out-of-window/unaligned addresses.
module sram_word_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    sram_word_controller_if.slave bus,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LD =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t               r_state;
    logic                 r_is_wr;
    logic [SRAM_AW-2:0]   r_waddr;
    logic [15:0]          r_wdata_hi;
    logic [31:0]          r_rdata;
    logic [3:0]           r_cnt;
    logic [15:0]          r_dq;
    logic                 r_dq_oe;
    logic [SRAM_AW-1:0]   r_addr;
    logic                 r_we_n;
    logic                 r_oe_n;

    logic                 w_req;
    logic [31:0]          w_off;
    logic [SRAM_AW-2:0]   w_waddr;
    logic                 w_bad;

    assign w_req   = bus.rd_en | bus.wr_en;
    assign w_off   = bus.address - 32'(BASE_ADDR);
    assign w_waddr = (SRAM_AW-1)'(w_off >> 2);

`ifdef SRAM_RANGE_CHECK_EN
    localparam logic [33:0] LO_ADDR = 34'(BASE_ADDR);
    localparam logic [33:0] HI_ADDR = LO_ADDR + (34'd1 << (SRAM_AW + 1));

    logic r_err;

    assign w_bad = ({2'b00, bus.address} < LO_ADDR)
                 | ({2'b00, bus.address} >= HI_ADDR)
                 | (bus.address[1:0] != 2'b00);
    assign bus.addr_err = r_err;
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_wr    <= 1'b0;
            r_waddr    <= '0;
            r_wdata_hi <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_dq       <= '0;
            r_dq_oe    <= 1'b0;
            r_addr     <= '0;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
            r_err      <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // Write wins when both strobes are set.
                        r_is_wr    <= bus.wr_en;
                        r_waddr    <= w_waddr;
                        r_wdata_hi <= bus.write_data[31:16];
                        if (w_bad) begin
                            r_state <= S_DONE;
`ifdef SRAM_RANGE_CHECK_EN
                            r_err   <= 1'b1;
`endif
                        end else begin
                            r_state <= S_LOW;
                            r_addr  <= {w_waddr, 1'b0};
                            r_we_n  <= ~bus.wr_en;
                            r_oe_n  <= bus.wr_en;
                            r_dq    <= bus.write_data[15:0];
                            r_dq_oe <= bus.wr_en;
                        end
                    end
                end
                S_LOW: begin
                    if (!r_is_wr) begin
                        r_rdata[15:0] <= SRAM_DQ;
                    end
                    r_addr  <= {r_waddr, 1'b1};
                    r_dq    <= r_wdata_hi;
                    r_state <= S_HIGH;
                end
                S_HIGH: begin
                    if (!r_is_wr) begin
                        r_rdata[31:16] <= SRAM_DQ;
                    end
                    r_we_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_cnt   <= WAIT_LD;
                    r_state <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef SRAM_RANGE_CHECK_EN
                    r_err   <= 1'b0;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready     = ~w_req | (r_state == S_DONE);
    assign bus.read_data = r_rdata;

    assign SRAM_DQ   = r_dq_oe ? r_dq : 16'hzzzz;
    assign SRAM_ADDR = r_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_word_controller.sv
// Bench for sram_word_controller: async SRAM model plus word-level reference.
// Two instances: default wait timing and WAIT_CYCLES=0.
module tb_sram_word_controller;
  localparam int BASE  = 1024;
  localparam int AW    = 18;
  localparam int WAITC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  sram_word_controller_if bus();
  sram_word_controller_if bus0();

  wire  [15:0]   dq;
  wire  [15:0]   dq0;
  logic [AW-1:0] sa, sa0;
  logic we_n, oe_n, ce_n, ub_n, lb_n;
  logic we0_n, oe0_n, ce0_n, ub0_n, lb0_n;

  sram_word_controller #(
    .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC), .SRAM_AW(AW)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .SRAM_DQ(dq), .SRAM_ADDR(sa),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
  );

  sram_word_controller #(
    .BASE_ADDR(BASE), .WAIT_CYCLES(0), .SRAM_AW(AW)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
    .SRAM_WE_N(we0_n), .SRAM_OE_N(oe0_n),
    .SRAM_CE_N(ce0_n), .SRAM_UB_N(ub0_n), .SRAM_LB_N(lb0_n)
  );

  logic [15:0] mem  [0:(1<<AW)-1];
  logic [15:0] mem0 [0:(1<<AW)-1];

  assign dq  = (!oe_n && we_n) ? mem[sa] : 16'hzzzz;
  assign dq0 = (!oe0_n && we0_n) ? mem0[sa0] : 16'hzzzz;

  always @(posedge clk) begin
    if (!we_n) mem[sa] = dq;
    if (!we0_n) mem0[sa0] = dq0;
  end

  logic [31:0] ref_w [int unsigned];
  logic [31:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned waddr_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'(BASE);
    return (off >> 2) & ((32'd1 << (AW-1)) - 32'd1);
  endfunction

  function automatic bit legal(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return (x >= BASE) && (x < BASE + (longint'(4) << (AW-1)))
           && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_w.exists(w) ? ref_w[w] : 32'd0;
  endfunction

  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit drop);
    int n;
    bit ok, done, dropped;
    int unsigned w;
    ok = 1'b1;
`ifdef SRAM_RANGE_CHECK_EN
    ok = legal(a);
`endif
    w = waddr_of(a);
    @(posedge clk); #1;
    bus.wr_en = wr; bus.rd_en = rd;
    bus.address = a; bus.write_data = d;
    n = 0; done = 1'b0; dropped = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!ok) chk("no_strobe", {30'd0, we_n, oe_n}, 32'd3);
      if (bus.ready) begin
        done = 1'b1;
      end else begin
        n++;
        @(posedge clk); #1;
        if (drop && n == 2) begin
          bus.wr_en = 1'b0; bus.rd_en = 1'b0;
          repeat (6) @(posedge clk);
          #1;
          dropped = 1'b1;
          done = 1'b1;
        end
      end
    end
    chk("timeout", 32'(done), 32'd1);
    if (ok) begin
      if (wr) ref_w[w] = d;
      else if (rd) exp_rd = ref_rd(w);
    end
    if (!dropped) begin
      chk("latency", n, ok ? 3 + WAITC : 1);
`ifdef SRAM_RANGE_CHECK_EN
      chk("addr_err", 32'(bus.addr_err), 32'(!ok));
`endif
    end
    chk("read_data", bus.read_data, exp_rd);
    if (wr && ok) begin
      chk("mem_lo", 32'(mem[2*w]), 32'(d[15:0]));
      chk("mem_hi", 32'(mem[2*w+1]), 32'(d[31:16]));
    end
    if (!dropped) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    end
    @(negedge clk);
    chk("ready_idle", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int n0;
    bit d0;
    logic [31:0] a, d;
    int sel, k, op;
    foreach (mem[i]) begin
      mem[i]  = 16'd0;
      mem0[i] = 16'd0;
    end
    exp_rd = 32'd0;
    bus.rd_en = 0; bus.wr_en = 0; bus.address = 0; bus.write_data = 0;
    bus0.rd_en = 0; bus0.wr_en = 0; bus0.address = 0; bus0.write_data = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_oe_n", 32'(oe_n), 32'd1);
    chk("rst_rdata", bus.read_data, 32'd0);
    chk("rst_addr", 32'(sa), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", 32'(bus.ready), 32'd1);
    chk("idle_we_n", 32'(we_n), 32'd1);

    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
    chk("hw0", 32'(mem[0]), 32'h0000BEEF);
    chk("hw1", 32'(mem[1]), 32'h0000DEAD);
    access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
    chk("rd_dead", bus.read_data, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 1'b0);
    chk("rd_hold", bus.read_data, 32'hDEADBEEF);

    @(posedge clk); #1;
    bus0.rd_en = 1; bus0.wr_en = 1;
    bus0.address = 32'd1032; bus0.write_data = 32'h12345678;
    n0 = 0; d0 = 1'b0;
    for (int i = 0; i < 20 && !d0; i++) begin
      @(negedge clk);
      if (bus0.ready) d0 = 1'b1;
      else begin
        n0++;
        @(posedge clk); #1;
      end
    end
    chk("w0_done", 32'(d0), 32'd1);
    chk("w0_latency", n0, 3);
    chk("w0_hw4", 32'(mem0[4]), 32'h00005678);
    chk("w0_hw5", 32'(mem0[5]), 32'h00001234);
    chk("w0_rdata", bus0.read_data, 32'd0);
    @(posedge clk); #1;
    bus0.rd_en = 0; bus0.wr_en = 0;

    @(posedge clk); #1;
    bus.rd_en = 1; bus.address = 32'd1024;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_oe_n", 32'(oe_n), 32'd0);
    chk("mid_lo", 32'(bus.read_data[15:0]), 32'h0000BEEF);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe_n", 32'(oe_n), 32'd1);
    chk("mid_rst_rdata", bus.read_data, 32'd0);
    chk("mid_rst_addr", 32'(sa), 32'd0);
    bus.rd_en = 0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    exp_rd = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;

    access(1'b0, 1'b1, 32'd1000, 32'd0, 1'b0);

    for (int it = 0; it < 150; it++) begin
      sel = $urandom_range(0, 9);
      k = $urandom_range(0, 31);
      if (sel < 6) a = 32'(BASE + 4*k);
      else if (sel == 6) a = 32'(BASE + 4*((1 << (AW-1)) + k));
      else if (sel == 7) a = 32'(BASE + 4*k + $urandom_range(1, 3));
      else if (sel == 8) a = 32'(BASE - 4*(k+1));
      else a = 32'(BASE + 4*((1 << (AW-1)) - 1 - k));
      d = $urandom;
      op = $urandom_range(0, 2);
      access(op != 0, op != 1, a, d, $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_word_controller.md
Name: sram_word_controller

Overview:
- Memory-stage block downstream of the decode/control path. It consumes the pipelined mem_read/mem_write strobes, the ALU-computed address and the store data.
- Performs each 32-bit access as two sequential 16-bit accesses on an external asynchronous SRAM.
- Holds ready low to freeze the pipeline until the access completes.
- Read data is registered and presented to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 3: extra idle cycles after the second half-access, to meet SRAM cycle time; legal range 0..15.
- SRAM_AW, 18: SRAM address bus width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_en  input  1  read request (pipelined mem_read); level, held by the pipeline while ready=0.
- wr_en  input  1  write request (pipelined mem_write); level, held while ready=0.
- address  input  32  byte address from the EXE stage.
- write_data  input  32  store data.
- read_data  output  32  registered load data.
- ready  output  1  0 = freeze pipeline; 1 = no access pending or access completing.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  SRAM_AW  SRAM half-word address.
- SRAM_WE_N  output  1  active-low write enable.
- SRAM_OE_N  output  1  active-low output enable.
- SRAM_CE_N  output  1  active-low chip enable; tied 0.
- SRAM_UB_N, SRAM_LB_N  output  1 each  byte lanes; tied 0.

Behaviour:
- Address map: waddr = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits.
  - Low half uses SRAM_ADDR = {waddr, 0}; it holds bits [15:0].
  - High half uses SRAM_ADDR = {waddr, 1}; it holds bits [31:16].
- Reset state: IDLE. read_data=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ released to high-Z.
- FSM states: IDLE, LOW, HIGH, WAIT, DONE.
  - IDLE: if rd_en|wr_en, latch the operation (write wins if both are set) and waddr, then go to LOW. Otherwise stay.
  - LOW: drive the low-half address. Write: SRAM_WE_N=0 and DQ=write_data[15:0]. Read: SRAM_OE_N=0 and capture DQ into read_data[15:0] at the clock edge. Go to HIGH.
  - HIGH: same as LOW for the high half, using bits [31:16]. Go to WAIT, or to DONE if WAIT_CYCLES=0.
  - WAIT: WE_N=OE_N=1, DQ high-Z, down-counter runs. Go to DONE when the count is exhausted (exactly WAIT_CYCLES cycles).
  - DONE: ready=1 for one cycle. Go to IDLE.
- ready, combinational:
  - ready = ~(rd_en|wr_en) | (state==DONE).
  - With no request, ready=1 from reset onward.
- Latency: a request first seen in IDLE at cycle 0 gives ready=0 for cycles 0..(2+WAIT_CYCLES). Ready is 1 in DONE at cycle 3+WAIT_CYCLES; default total is 7 cycles.
- read_data:
  - Updated only by reads.
  - Holds its value across writes and idle periods until the next read's LOW/HIGH captures.
- Back-to-back requests: a request still asserted in the cycle after DONE (back in IDLE) is a new access. The pipeline advances on DONE, so these are the next instruction's strobes.
- Request dropped mid-access (pipeline flush): the access still completes to DONE. Write data and address were latched in IDLE, so SRAM contents are deterministic.
- DQ drive: driven only in LOW/HIGH during a write; high-Z in every other state. No bus contention with OE_N=0.
- Reset mid-access: all outputs return to reset values immediately. A partial write may leave one half updated; this is acceptable.

Optional Feature:
- Macro SRAM_RANGE_CHECK_EN.
- When defined:
  - Adds output addr_err (1 bit, reset 0).
  - A request whose address is below BASE_ADDR, at or above BASE_ADDR + 4*2^(SRAM_AW-1), or not word-aligned goes IDLE -> DONE directly.
  - No SRAM strobes are issued; read_data is unchanged.
  - addr_err=1 during that DONE cycle only.
- When undefined: no addr_err port; every address is translated by truncation as above.

Test Plan:
- Reset then idle: rst pulse, rd_en=wr_en=0 -> ready=1, WE_N=OE_N=1, DQ high-Z, read_data=0.
- Write: wr_en=1, address=1024, write_data=0xDEADBEEF -> ready low 6 cycles then high 1 cycle. SRAM model holds 0xBEEF at half-word 0 and 0xDEAD at half-word 1.
- Read back: rd_en=1, address=1024 -> read_data=0xDEADBEEF at DONE. The value is held through a following write to 1028.
- Priority and latency: rd_en=wr_en=1, address=1032, data=0x12345678, WAIT_CYCLES=0 -> write performed. Ready low 3 cycles. Halves written at 4/5.
- Reset mid-access: assert rst during HIGH of a read -> next cycle state is IDLE, OE_N=1, read_data=0, ready=1 with no request.
- With SRAM_RANGE_CHECK_EN: rd_en=1, address=1000 -> no SRAM strobe. DONE after 1 cycle with addr_err=1; read_data unchanged.
